// File: rtl/mem_access_controller.sv
// Data-memory access sequencer: req/ack handshake with timeout, pipeline stall,
// store lane steering and load lane extraction with sign/zero extension.
module mem_access_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ALU_outM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic                  MemWriteM_i,
  input  logic                  ResultSrcM_i,
  input  logic [1:0]            ByteSelectM_i,
  input  logic                  MemExtendM_i,
  output logic                  StallM_o,
  output logic [DATA_WIDTH-1:0] ReadDataM_o,
  output logic                  MisalignM_o,
  output logic                  MemFaultM_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state, stateNext;
  logic [CW-1:0]         waitCnt;
  logic [1:0]            fmtQ;
  logic [1:0]            offQ;
  logic                  extQ;
  logic [DATA_WIDTH-1:0] readDataQ;
  logic                  faultQ;

  logic                  access, isHalf, isByte, isWord, misaligned;
  logic                  issue, ackTake, timeout, stallRaw;
  logic [DATA_WIDTH-1:0] wdataNext, loadExt;
  logic [3:0]            wstrbNext;
  logic [7:0]            byteLane;
  logic [15:0]           halfLane;

  assign access     = MemWriteM_i | ResultSrcM_i;
  assign isHalf     = (ByteSelectM_i == 2'b01);
  assign isByte     = (ByteSelectM_i == 2'b10);
  assign isWord     = ~isHalf & ~isByte;
  assign misaligned = (isHalf & ALU_outM_i[0]) | (isWord & (|ALU_outM_i[1:0]));

  assign MisalignM_o = access & misaligned;
  assign StallM_o    = rst_n & stallRaw;
  assign MemFaultM_o = faultQ;
  assign ReadDataM_o = MisalignM_o ? '0 : readDataQ;

  // Store lane steering from the live pipeline inputs, registered at issue.
  always_comb begin
    wdataNext = WriteDataM_i;
    wstrbNext = 4'b1111;
    if (isByte) begin
      wdataNext = {4{WriteDataM_i[7:0]}};
      wstrbNext = 4'b0001 << ALU_outM_i[1:0];
    end else if (isHalf) begin
      wdataNext = {2{WriteDataM_i[15:0]}};
      wstrbNext = ALU_outM_i[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Load extraction uses the format captured at issue, not the live inputs.
  always_comb begin
    case (offQ)
      2'd0:    byteLane = mem_rdata_i[7:0];
      2'd1:    byteLane = mem_rdata_i[15:8];
      2'd2:    byteLane = mem_rdata_i[23:16];
      default: byteLane = mem_rdata_i[31:24];
    endcase
    halfLane = offQ[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    loadExt  = mem_rdata_i;
    if (fmtQ == 2'b10)
      loadExt = {{(DATA_WIDTH-8){extQ & byteLane[7]}}, byteLane};
    else if (fmtQ == 2'b01)
      loadExt = {{(DATA_WIDTH-16){extQ & halfLane[15]}}, halfLane};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    ackTake   = 1'b0;
    timeout   = 1'b0;
    stallRaw  = 1'b0;
    case (state)
      IDLE: begin
        stallRaw = access & ~misaligned;
        if (access && !misaligned) begin
          issue     = 1'b1;
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        stallRaw = 1'b1;
        // An ack on the final wait cycle still wins over the timeout.
        if (mem_ack_i) begin
          ackTake   = 1'b1;
          stateNext = DONE;
        end else if (waitCnt == CW'(MAX_WAIT - 1)) begin
          timeout   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= '0;
      waitCnt     <= '0;
      fmtQ        <= 2'b00;
      offQ        <= 2'b00;
      extQ        <= 1'b0;
      readDataQ   <= '0;
      faultQ      <= 1'b0;
    end else begin
      if (issue) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= MemWriteM_i;
        mem_addr_o  <= {ALU_outM_i[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_o <= wdataNext;
        mem_wstrb_o <= wstrbNext;
        fmtQ        <= ByteSelectM_i;
        offQ        <= ALU_outM_i[1:0];
        extQ        <= MemExtendM_i;
        waitCnt     <= '0;
      end
      if (ackTake) begin
        mem_req_o <= 1'b0;
        if (!mem_we_o) readDataQ <= loadExt;
      end else if (timeout) begin
        mem_req_o <= 1'b0;
        faultQ    <= 1'b1;
        readDataQ <= '0;
      end else if (state == ACCESS) begin
        waitCnt <= waitCnt + CW'(1);
      end
      if (state == DONE) faultQ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller with a per-cycle expectation model.
module tb_mem_access_controller;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ALU_outM_i = '0, WriteDataM_i = '0;
  logic        MemWriteM_i = 1'b0, ResultSrcM_i = 1'b0, MemExtendM_i = 1'b0;
  logic [1:0]  ByteSelectM_i = 2'b00;
  logic        StallM_o, MisalignM_o, MemFaultM_o, mem_req_o, mem_we_o;
  logic [31:0] ReadDataM_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  mem_access_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .ALU_outM_i(ALU_outM_i), .WriteDataM_i(WriteDataM_i),
    .MemWriteM_i(MemWriteM_i), .ResultSrcM_i(ResultSrcM_i), .ByteSelectM_i(ByteSelectM_i),
    .MemExtendM_i(MemExtendM_i), .StallM_o(StallM_o), .ReadDataM_o(ReadDataM_o),
    .MisalignM_o(MisalignM_o), .MemFaultM_o(MemFaultM_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected outputs for the cycle currently being observed.
  logic        cmpEn = 1'b0;
  logic        mStall = 1'b0, mReq = 1'b0, mMis = 1'b0, mFault = 1'b0, mWe = 1'b0;
  logic [31:0] mRead = '0, mReadReg = '0, mAddr = '0, mWdata = '0;
  logic [3:0]  mWstrb = '0;

  function automatic int fsz(input logic [1:0] f);
    return (f == 2'b10) ? 1 : (f == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic isMis(input logic [31:0] a, input logic [1:0] f);
    return (int'(a[1:0]) % fsz(f)) != 0;
  endfunction

  function automatic logic [31:0] expWdata(input logic [31:0] wd, input logic [1:0] f);
    logic [31:0] r;
    int sz;
    sz = fsz(f);
    r = '0;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % sz) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] expWstrb(input logic [31:0] a, input logic [1:0] f);
    logic [3:0] r;
    int sz, off;
    sz = fsz(f);
    off = int'(a[1:0]);
    for (int l = 0; l < 4; l++) r[l] = (l >= off) && (l < off + sz);
    return r;
  endfunction

  function automatic logic [31:0] expLoad(input logic [31:0] rd, input logic [31:0] a,
                                          input logic [1:0] f, input logic ext);
    logic [63:0] v, m;
    int sz, off;
    sz = fsz(f);
    off = int'(a[1:0]);
    v = 64'(rd) >> (8 * off);
    m = (64'd1 << (8 * sz)) - 64'd1;
    v = v & m;
    if (ext && v[8*sz-1]) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic setIn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic ld, input logic [1:0] f, input logic ext);
    ALU_outM_i = a; WriteDataM_i = wd; MemWriteM_i = we; ResultSrcM_i = ld;
    ByteSelectM_i = f; MemExtendM_i = ext;
  endtask

  task automatic modelIdle();
    mStall = 1'b0; mReq = 1'b0; mMis = 1'b0; mFault = 1'b0; mRead = mReadReg;
  endtask

  always begin
    @(negedge clk);
    #3;
    if (cmpEn) begin
      chk("stall", 32'(StallM_o), 32'(mStall));
      chk("req", 32'(mem_req_o), 32'(mReq));
      chk("misalign", 32'(MisalignM_o), 32'(mMis));
      chk("fault", 32'(MemFaultM_o), 32'(mFault));
      chk("rdata", ReadDataM_o, mRead);
      if (mReq) begin
        chk("we", 32'(mem_we_o), 32'(mWe));
        chk("addr", mem_addr_o, mAddr);
        chk("wdata", mem_wdata_o, mWdata);
        chk("wstrb", 32'(mem_wstrb_o), 32'(mWstrb));
      end
    end
  end

  // One aligned access; ackAt = ACCESS cycle carrying ack (1..MAXW), else no ack.
  task automatic runAccess(input logic [31:0] a, input logic [31:0] wd, input logic we,
                           input logic ld, input logic [1:0] f, input logic ext,
                           input int ackAt, input logic [31:0] rd, input logic lateAck,
                           output int sc, output int rc, output int fc,
                           output logic [31:0] sa, output logic [31:0] sw,
                           output logic [3:0] ss);
    int n;
    logic tout;
    sc = 0; rc = 0; fc = 0; sa = '0; sw = '0; ss = '0;
    tout = !(ackAt >= 1 && ackAt <= MAXW);
    n = tout ? MAXW : ackAt;
    @(negedge clk);
    setIn(a, wd, we, ld, f, ext);
    mem_ack_i = 1'b0;
    modelIdle();
    mStall = 1'b1;
    #3 sc += int'(StallM_o); rc += int'(mem_req_o); fc += int'(MemFaultM_o);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      mem_ack_i = !tout && (i == n);
      mem_rdata_i = rd;
      mStall = 1'b1; mReq = 1'b1; mWe = we;
      mAddr = {a[31:2], 2'b00};
      mWdata = expWdata(wd, f);
      mWstrb = expWstrb(a, f);
      #3 sc += int'(StallM_o); rc += int'(mem_req_o); fc += int'(MemFaultM_o);
      sa = mem_addr_o; sw = mem_wdata_o; ss = mem_wstrb_o;
    end
    @(negedge clk);
    setIn('0, '0, 1'b0, 1'b0, 2'b00, 1'b0);
    mem_ack_i = lateAck;
    mem_rdata_i = 32'hA5A5A5A5;
    if (tout) mReadReg = '0;
    else if (!we) mReadReg = expLoad(rd, a, f, ext);
    modelIdle();
    mFault = tout;
    #3 sc += int'(StallM_o); rc += int'(mem_req_o); fc += int'(MemFaultM_o);
    @(negedge clk);
    modelIdle();
    #3 sc += int'(StallM_o); rc += int'(mem_req_o); fc += int'(MemFaultM_o);
  endtask

  task automatic runMis(input logic [31:0] a, input logic we, input logic ld,
                        input logic [1:0] f, output int rc, output int sc);
    rc = 0; sc = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      setIn(a, 32'h11223344, we, ld, f, 1'b1);
      mem_ack_i = 1'b0;
      modelIdle();
      mMis = isMis(a, f);
      mRead = '0;
      #3 rc += int'(mem_req_o); sc += int'(StallM_o);
    end
    @(negedge clk);
    setIn('0, '0, 1'b0, 1'b0, 2'b00, 1'b0);
    modelIdle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, rc, fc;
    logic [31:0] sa, sw;
    logic [3:0] ss;

    repeat (2) @(negedge clk);
    #3;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb_o), 32'd0);
    chk("rst_stall", 32'(StallM_o), 32'd0);
    chk("rst_rdata", ReadDataM_o, 32'd0);
    chk("rst_fault", 32'(MemFaultM_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mReadReg = '0;
    modelIdle();
    cmpEn = 1'b1;

    runAccess(32'h100, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0, 1, 32'hDEADBEEF, 1'b0, sc, rc, fc, sa, sw, ss);
    chk("wl_stall_cycles", sc, 2);
    chk("wl_req_cycles", rc, 1);
    chk("wl_addr", sa, 32'h100);
    chk("wl_rdata", ReadDataM_o, 32'hDEADBEEF);

    runAccess(32'h103, 32'h0, 1'b0, 1'b1, 2'b10, 1'b1, 1, 32'h80FF1234, 1'b0, sc, rc, fc, sa, sw, ss);
    chk("lb_signed", ReadDataM_o, 32'hFFFFFF80);
    runAccess(32'h103, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1, 32'h80FF1234, 1'b0, sc, rc, fc, sa, sw, ss);
    chk("lb_unsigned", ReadDataM_o, 32'h00000080);

    runAccess(32'h102, 32'h0000BEEF, 1'b1, 1'b0, 2'b01, 1'b0, 4, 32'h0, 1'b0, sc, rc, fc, sa, sw, ss);
    chk("sh_wdata", sw, 32'hBEEFBEEF);
    chk("sh_wstrb", 32'(ss), 32'hC);
    chk("sh_addr", sa, 32'h100);
    chk("sh_req_cycles", rc, 4);
    chk("sh_stall_cycles", sc, 5);
    chk("sh_rdata_held", ReadDataM_o, 32'h00000080);

    runMis(32'h101, 1'b0, 1'b1, 2'b00, rc, sc);
    chk("mis_word_req", rc, 0);
    chk("mis_word_stall", sc, 0);
    runMis(32'h103, 1'b1, 1'b0, 2'b01, rc, sc);
    chk("mis_half_req", rc, 0);
    runMis(32'h102, 1'b0, 1'b1, 2'b11, rc, sc);
    chk("mis_fmt3_req", rc, 0);

    runAccess(32'h40, 32'h12345678, 1'b1, 1'b0, 2'b00, 1'b0, 0, 32'h0, 1'b1, sc, rc, fc, sa, sw, ss);
    chk("to_req_cycles", rc, 4);
    chk("to_stall_cycles", sc, 5);
    chk("to_fault_cycles", fc, 1);

    runAccess(32'h101, 32'h000000AB, 1'b1, 1'b1, 2'b10, 1'b0, 2, 32'hFFFFFFFF, 1'b0, sc, rc, fc, sa, sw, ss);
    chk("sb_wdata", sw, 32'hABABABAB);
    chk("sb_wstrb", 32'(ss), 32'h2);
    chk("sb_rdata_held", ReadDataM_o, 32'h0);

    runAccess(32'h102, 32'h0, 1'b0, 1'b1, 2'b01, 1'b1, 3, 32'h80017FFF, 1'b0, sc, rc, fc, sa, sw, ss);
    chk("lh_signed", ReadDataM_o, 32'hFFFF8001);

    runAccess(32'h8, 32'hCAFEF00D, 1'b1, 1'b0, 2'b11, 1'b0, 1, 32'h0, 1'b0, sc, rc, fc, sa, sw, ss);
    chk("sw_wdata", sw, 32'hCAFEF00D);
    chk("sw_wstrb", 32'(ss), 32'hF);

    cmpEn = 1'b0;
    @(negedge clk);
    setIn(32'h300, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
    mem_ack_i = 1'b0;
    @(negedge clk);
    #1 chk("rst_mid_req_before", 32'(mem_req_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req_o), 32'd0);
    chk("rst_mid_stall", 32'(StallM_o), 32'd0);
    @(negedge clk);
    setIn('0, '0, 1'b0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack_i = 1'b0;
    #3;
    chk("post_rst_req", 32'(mem_req_o), 32'd0);
    chk("post_rst_stall", 32'(StallM_o), 32'd0);
    chk("post_rst_rdata", ReadDataM_o, 32'd0);
    chk("post_rst_fault", 32'(MemFaultM_o), 32'd0);
    mReadReg = '0;
    @(negedge clk);
    modelIdle();
    cmpEn = 1'b1;

    runAccess(32'h200, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0, 2, 32'h0BADF00D, 1'b0, sc, rc, fc, sa, sw, ss);
    chk("after_rst_stall_cycles", sc, 3);
    chk("after_rst_rdata", ReadDataM_o, 32'h0BADF00D);

    cmpEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
